// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the packet arbiter: FSM states, header word layout, counter widths.
// Header word (when compiled in) carries a per-source sequence number above an 8-bit source id.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    XFER = 2'd2
  } arb_state_t;

  localparam int HDR_ID_LSB  = 0;
  localparam int HDR_SEQ_LSB = 8;
  localparam int HDR_SEQ_W   = 32;
  localparam int PKT_CNT_W   = 32;
  localparam int HDR_ID_W    = HDR_SEQ_LSB - HDR_ID_LSB;

  typedef struct packed {
    logic [HDR_SEQ_W-1:0] seq;
    logic [HDR_ID_W-1:0]  id;
  } hdr_t;

endpackage

// File: rtl/fifo_pkt_arbiter_rr_pick.sv
// Rotate-priority selector: first set request scanning upward from last_grant+1, modulo N.
// Latency: purely combinational; no backpressure (any=0 when no request is set).
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_grant,
  output logic            any,
  output logic [ID_W-1:0] idx
);

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    any   = |req;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // i == N wraps back to last_grant itself, so it has lowest priority
    for (int i = 1; i <= N; i++) begin
      cand = ID_W'((int'(last_grant) + i) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_pkt_arbiter.sv
// Round-robin packet arbiter onto one FIFO write port; grant held to s_last; header word when FIFO_ARB_HEADER_EN.
// Latency: one IDLE arbitration cycle per packet, beats pass through combinationally; fifo_full stalls all writes/accepts.
module fifo_pkt_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_SRC      = 4,
  parameter  int DATA_WIDTH = 64,
  localparam int ID_W       = $clog2(N_SRC)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_SRC-1:0]            s_valid,
  input  logic [N_SRC*DATA_WIDTH-1:0] s_data,
  input  logic [N_SRC-1:0]            s_last,
  output logic [N_SRC-1:0]            s_ready,
  output logic                        fifo_we,
  output logic [DATA_WIDTH-1:0]       fifo_din,
  input  logic                        fifo_full,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy,
  output logic [PKT_CNT_W-1:0]        pkt_count
);

  arb_state_t           state_q, state_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;

  logic                  pick_vld;
  logic [ID_W-1:0]       pick_idx;
  logic [DATA_WIDTH-1:0] src_dat [N_SRC];
  logic [DATA_WIDTH-1:0] grant_dat;

`ifdef FIFO_ARB_HEADER_EN
  logic [HDR_SEQ_W-1:0] seq_q [N_SRC];
  logic [HDR_SEQ_W-1:0] seq_d [N_SRC];
  hdr_t                 hdr_w;

  always_comb begin
    hdr_w.seq = seq_q[grant_id_q];
    hdr_w.id  = HDR_ID_W'(grant_id_q);
  end
`endif

  rr_pick #(
    .N    (N_SRC),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req        (s_valid),
    .last_grant (last_grant_q),
    .any        (pick_vld),
    .idx        (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_dat[i] = s_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    grant_dat = src_dat[grant_id_q];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    pkt_count_d  = pkt_count_q;
    s_ready      = '0;
    fifo_we      = 1'b0;
    fifo_din     = '0;
`ifdef FIFO_ARB_HEADER_EN
    seq_d        = seq_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_id_d = pick_idx;
`ifdef FIFO_ARB_HEADER_EN
          state_d    = HDR;
`else
          state_d    = XFER;
`endif
        end
      end
`ifdef FIFO_ARB_HEADER_EN
      HDR: begin
        fifo_we  = !fifo_full;
        fifo_din = DATA_WIDTH'(hdr_w);
        if (!fifo_full) begin
          state_d = XFER;
        end
      end
`endif
      XFER: begin
        s_ready[grant_id_q] = !fifo_full;
        fifo_we             = s_valid[grant_id_q] && !fifo_full;
        fifo_din            = grant_dat;
        if (fifo_we && s_last[grant_id_q]) begin
          pkt_count_d  = pkt_count_q + PKT_CNT_W'(1);
          last_grant_d = grant_id_q;
`ifdef FIFO_ARB_HEADER_EN
          seq_d[grant_id_q] = seq_q[grant_id_q] + HDR_SEQ_W'(1);
`endif
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(N_SRC - 1);
      grant_id_q   <= '0;
      pkt_count_q  <= '0;
`ifdef FIFO_ARB_HEADER_EN
      for (int i = 0; i < N_SRC; i++) begin
        seq_q[i] <= '0;
      end
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      pkt_count_q  <= pkt_count_d;
`ifdef FIFO_ARB_HEADER_EN
      seq_q        <= seq_d;
`endif
    end
  end

  assign grant_id  = grant_id_q;
  assign busy      = (state_q != IDLE);
  assign pkt_count = pkt_count_q;

endmodule
